// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulator store queue.
package acc_pkg;

  localparam int ACC_DW = 8;
  localparam int ACC_AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sq_state_t;

  typedef struct packed {
    logic [ACC_AW-1:0] addr;
    logic [ACC_DW-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/sq_fwd_match.sv
// Store-to-load forwarding search: finds the youngest occupied entry whose
// address matches the load probe. Only instantiated when ACC_STORE_FWD_EN
// is defined.
module sq_fwd_match #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input  logic [AW-1:0]            addr_q [DEPTH],
  input  logic [DW-1:0]            data_q [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk occupied entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ld_valid && (CW'(k) < count) && (addr_q[idx] == ld_addr)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/acc_store_queue.sv
// Accumulator store queue: buffers stores and retires them in FIFO order to
// data memory, with an explicit drain/flush handshake.
// Optional feature macro: ACC_STORE_FWD_EN enables store-to-load forwarding.
//
// state | meaning
// IDLE  | no write presented; waits for an entry or a drain request
// ISSUE | presenting head entry to memory until mem_ack
// DRAIN | flushing all entries, new stores blocked, drain_done at empty
module acc_store_queue
  import acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = ACC_DW,
  parameter int AW    = ACC_AW
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [DW-1:0]          acc_in,
  input  logic [AW-1:0]          addr_in,
  input  logic                   st_valid,
  output logic                   st_ready,
  output logic                   mem_wr_en,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  sq_state_t     state;

  // A pop never frees a slot for a push in the same cycle: readiness uses registered count.
  assign st_ready  = (count < DEPTH_C) && (state != DRAIN);
  assign push      = st_valid && st_ready;
  assign pop       = mem_wr_en && mem_ack;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign mem_addr  = mem_wr_en ? addr_q[head] : '0;
  assign mem_wdata = mem_wr_en ? data_q[head] : '0;

  // Entry storage; stale contents are harmless since occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail] <= addr_in;
      data_q[tail] <= acc_in;
    end
  end

  // Head/tail pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_nxt;
    end
  end

  // Sequencer: decides when a write is presented and when a drain completes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      mem_wr_en  <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_req) begin
            state     <= DRAIN;
            mem_wr_en <= (count_nxt != '0);
          end else if (count != '0) begin
            state     <= ISSUE;
            mem_wr_en <= 1'b1;
          end
        end
        ISSUE: begin
          mem_wr_en <= (count_nxt != '0);
          if (drain_req)
            state <= DRAIN;
          else if (count_nxt == '0)
            state <= IDLE;
        end
        DRAIN: begin
          mem_wr_en <= (count_nxt != '0);
          if (count_nxt == '0) begin
            drain_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACC_STORE_FWD_EN
  sq_fwd_match #(
    .DEPTH(DEPTH),
    .DW   (DW),
    .AW   (AW)
  ) u_fwd (
    .addr_q  (addr_q),
    .data_q  (data_q),
    .head    (head),
    .count   (count),
    .ld_valid(ld_valid),
    .ld_addr (ld_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_addr};
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_acc_store_queue.sv
// Self-checking bench for acc_store_queue (DEPTH=4, DW=AW=8).
module tb_acc_store_queue;

  logic       CLK;
  logic       RST_N;
  logic [7:0] acc_in;
  logic [7:0] addr_in;
  logic       st_valid;
  logic       st_ready;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic       ld_valid;
  logic [7:0] ld_addr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic       drain_req;
  logic       drain_done;
  logic [2:0] count;

  acc_store_queue #(.DEPTH(4), .DW(8), .AW(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .acc_in    (acc_in),
    .addr_in   (addr_in),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .drain_req (drain_req),
    .drain_done(drain_done),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb[$];
  logic [7:0]  wlog[$];
  int          mcount = 0;
  logic        m_drain = 1'b0;
  logic        last_push = 1'b0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score the pre-edge handshakes, advance, then check the model.
  task automatic tick();
    logic        exp_ready;
    logic        pushed;
    logic        popped;
    logic        prev_drain;
    logic        dr;
    logic        exp_done;
    logic [15:0] e;
    pushed     = 1'b0;
    popped     = 1'b0;
    exp_done   = 1'b0;
    prev_drain = m_drain;
    dr         = drain_req;
    if (RST_N) begin
      exp_ready = (mcount < 4) && !m_drain;
      check("st_ready", st_ready, exp_ready);
      pushed = st_valid && exp_ready;
      if (pushed) sb.push_back({addr_in, acc_in});
      popped = mem_wr_en && mem_ack;
      if (popped) begin
        if (sb.size() == 0) begin
          check("pop_on_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check("mem_addr", mem_addr, e[15:8]);
          check("mem_wdata", mem_wdata, e[7:0]);
          wlog.push_back(mem_wdata);
        end
      end
    end
    @(posedge CLK);
    #1;
    if (!RST_N) begin
      sb.delete();
      mcount  = 0;
      m_drain = 1'b0;
    end else begin
      mcount   = mcount + int'(pushed) - int'(popped);
      exp_done = prev_drain && (mcount == 0);
      m_drain  = prev_drain ? !exp_done : dr;
    end
    last_push = pushed;
    check("count", count, mcount);
    check("drain_done", drain_done, exp_done);
    if (drain_done) done_cnt++;
  endtask

  task automatic push_one(input logic [7:0] a, input logic [7:0] d);
    st_valid = 1'b1;
    addr_in  = a;
    acc_in   = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    mem_ack = 1'b1;
    for (int c = 0; c < 40 && mcount > 0; c++) tick();
    mem_ack = 1'b0;
    check("drain_all_empty", mcount, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; acc_in = '0; addr_in = '0; st_valid = 1'b0; mem_ack = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; drain_req = 1'b0;

    // Reset state
    tick();
    tick();
    RST_N = 1'b1;
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_mem_addr", mem_addr, 0);

    // Single store: one-cycle latency then retire
    push_one(8'h10, 8'h2A);
    check("single_wr_en_idle", mem_wr_en, 0);
    tick();
    check("single_wr_en", mem_wr_en, 1);
    check("single_addr", mem_addr, 8'h10);
    check("single_data", mem_wdata, 8'h2A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("single_wr_en_after", mem_wr_en, 0);
    tick();
    check("single_still_idle", mem_wr_en, 0);

    // Full queue: 4 pushes, 5th refused, one ack reopens
    for (int i = 0; i < 4; i++) push_one(8'(8'h40 + i), 8'(8'h31 + i));
    check("full_count", count, 4);
    check("full_st_ready", st_ready, 0);
    push_one(8'h99, 8'h99);
    check("full_5th_refused", last_push, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("full_reopen", st_ready, 1);
    drain_all();
    tick();

    // Ordering and wrap under intermittent ack
    wlog.delete();
    begin
      int i;
      i = 0;
      for (int c = 0; c < 200 && (i < 6 || mcount > 0); c++) begin
        st_valid = (i < 6);
        addr_in  = 8'(8'h50 + i);
        acc_in   = 8'(i + 1);
        mem_ack  = ((c % 3) != 1);
        tick();
        if (last_push) i++;
      end
      st_valid = 1'b0;
      mem_ack  = 1'b0;
      check("order_pushed", i, 6);
    end
    check("order_len", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) check("order_data", wlog[k], k + 1);
    tick();

    // Drain: 3 entries, stores blocked, single done pulse
    done_cnt = 0;
    for (int i = 0; i < 3; i++) push_one(8'(8'h60 + i), 8'(8'h61 + i));
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("drain_st_ready", st_ready, 0);
    mem_ack  = 1'b1;
    st_valid = 1'b1; addr_in = 8'hEE; acc_in = 8'hEE;
    tick();
    st_valid  = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("drain_st_ready_mid", st_ready, 0);
    tick();
    check("drain_done_pulse", drain_done, 1);
    tick();
    mem_ack = 1'b0;
    check("drain_wr_en_off", mem_wr_en, 0);
    check("drain_done_once", done_cnt, 1);

    // Forwarding probe
    push_one(8'h20, 8'h11);
    push_one(8'h20, 8'h22);
    ld_valid = 1'b1;
    ld_addr  = 8'h20;
    #1;
`ifdef ACC_STORE_FWD_EN
    check("fwd_hit_20", fwd_hit, 1);
    check("fwd_data_20", fwd_data, 8'h22);
`else
    check("fwd_off_hit", fwd_hit, 0);
    check("fwd_off_data", fwd_data, 0);
`endif
    ld_addr = 8'h21;
    #1;
    check("fwd_miss_21", fwd_hit, 0);
    ld_addr  = 8'h30;
    st_valid = 1'b1; addr_in = 8'h30; acc_in = 8'h33;
    #1;
    check("fwd_same_cycle", fwd_hit, 0);
    tick();
    st_valid = 1'b0;
`ifdef ACC_STORE_FWD_EN
    check("fwd_after_push", fwd_hit, 1);
    check("fwd_after_data", fwd_data, 8'h33);
`else
    check("fwd_off_after", fwd_hit, 0);
`endif
    ld_valid = 1'b0;
    drain_all();
    tick();

    // Reset mid-write
    push_one(8'h70, 8'h71);
    push_one(8'h72, 8'h73);
    check("rstmid_wr_en", mem_wr_en, 1);
    check("rstmid_count", count, 2);
    mem_ack = 1'b1;
    RST_N   = 1'b0;
    tick();
    check("rstmid_wr_en_off", mem_wr_en, 0);
    RST_N   = 1'b1;
    mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rstmid_no_reissue", mem_wr_en, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_store_queue.md
ACC_STORE_QUEUE -- requirements
Module: acc_store_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4: number of store-buffer entries; power of two, 2..16.
REQ-002 The module SHALL have parameter DW, default 8: data width, equal to the accumulator width.
REQ-003 The module SHALL have parameter AW, default 8: data-memory address width.
REQ-004 The clock and reset SHALL be one clock and a synchronous, active-low reset, with ports CLK (in, 1, all state updates on posedge) and RST_N (in, 1, synchronous active-low reset).
REQ-005 The module SHALL have the port acc_in, in, DW: store data from the accumulator output.
REQ-006 The module SHALL have the port addr_in, in, AW: store target address.
REQ-007 The module SHALL have the port st_valid, in, 1: store request.
REQ-008 The module SHALL have the port st_ready, out, 1: queue can accept a store this cycle.
REQ-009 The module SHALL have the ports mem_wr_en, out, 1; mem_addr, out, AW; mem_wdata, out, DW: memory write request.
REQ-010 The module SHALL have the port mem_ack, in, 1: memory accepted the presented write.
REQ-011 The module SHALL have the ports ld_valid, in, 1, and ld_addr, in, AW: load address probe.
REQ-012 The module SHALL have the ports fwd_hit, out, 1, and fwd_data, out, DW: store-to-load forwarding result.
REQ-013 The module SHALL have the ports drain_req, in, 1, and drain_done, out, 1: flush request and its completion pulse.
REQ-014 The module SHALL have the port count, out, $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-015 The queue SHALL accept a store on a posedge where st_valid=1 and st_ready=1, writing {addr_in, acc_in} at the tail.
REQ-016 st_ready SHALL be 1 exactly when count<DEPTH and the FSM is not in DRAIN.
REQ-017 There SHALL be no full bypass: a pop in the same cycle SHALL NOT make st_ready 1 while count==DEPTH.
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-019 The FSM SHALL go from IDLE to ISSUE when count>0, and from IDLE to DRAIN when drain_req=1.
REQ-020 In ISSUE, the FSM SHALL hold mem_wr_en=1 with mem_addr and mem_wdata driven from the head entry, stable until mem_ack.
REQ-021 In ISSUE, on mem_ack the queue SHALL pop the head, then stay in ISSUE if count after the pop is >0; otherwise it SHALL return to IDLE.
REQ-022 drain_req=1 in ISSUE SHALL move the FSM to DRAIN on the next edge without dropping the in-flight write.
REQ-023 In DRAIN, the FSM SHALL keep issuing writes as in ISSUE.
REQ-024 When the DRAIN queue becomes empty, drain_done SHALL pulse 1 for one cycle and the FSM SHALL return to IDLE.
REQ-025 A drain_req while in DRAIN SHALL be ignored.
REQ-026 mem_wr_en SHALL be 0 in IDLE.
REQ-027 mem_addr and mem_wdata SHALL be don't-care when mem_wr_en=0 and SHALL be driven to 0.
REQ-028 Minimum latency SHALL be one cycle: a store accepted at edge N into an empty IDLE queue drives mem_wr_en=1 after edge N+1.
REQ-029 A simultaneous push and pop SHALL leave count unchanged.
REQ-030 Entries SHALL retire strictly in FIFO order, and head and tail pointers SHALL wrap modulo DEPTH.
REQ-031 A mem_ack received while mem_wr_en=0 SHALL be ignored.

Reset
REQ-032 When RST_N=0 at a posedge, the block SHALL discard all entries, zero both pointers, and set count=0, state=IDLE, mem_wr_en=0, drain_done=0 and fwd_hit=0.
REQ-033 A reset asserted mid-handshake SHALL abandon the write: no pop occurs and mem_wr_en is 0 after that edge.

Configuration
REQ-034 With macro ACC_STORE_FWD_EN defined, the block SHALL assert fwd_hit combinationally when ld_valid=1 and any occupied entry matches ld_addr.
REQ-035 With ACC_STORE_FWD_EN defined, fwd_data SHALL come from the youngest matching entry.
REQ-036 With ACC_STORE_FWD_EN defined, a store being pushed in the same cycle SHALL NOT be forwarded.
REQ-037 Without ACC_STORE_FWD_EN, fwd_hit SHALL be tied to 0, fwd_data SHALL be tied to 0, and the block SHALL contain no comparator logic.

Structure
REQ-038 Package acc_pkg SHALL hold DW/AW defaults, the enum sq_state_t {IDLE, ISSUE, DRAIN}, and the struct sq_entry_t {addr, data}.
REQ-039 Sub-module sq_fwd_match SHALL implement the youngest-match priority search and SHALL be instantiated only under ACC_STORE_FWD_EN.

Verification
REQ-040 The bench SHALL cover single store: push addr=0x10, data=0x2A into an empty queue -> mem_wr_en=1 next cycle with addr 0x10 and data 0x2A; mem_ack -> count=0 and IDLE.
REQ-041 The bench SHALL cover full queue: 4 pushes with mem_ack held 0 -> count=4 and st_ready=0; a 5th push with st_valid=1 is not accepted; one mem_ack -> st_ready=1 next cycle.
REQ-042 The bench SHALL cover ordering and wrap: 6 stores with data 1..6 under intermittent mem_ack -> mem_wdata sequence is exactly 1..6.
REQ-043 The bench SHALL cover drain: 3 entries, then drain_req -> st_ready=0 until empty, and drain_done pulses once after the 3rd mem_ack.
REQ-044 The bench SHALL cover forwarding (ACC_STORE_FWD_EN): stores (0x20,0x11) then (0x20,0x22) -> ld_addr=0x20 gives fwd_hit=1 and fwd_data=0x22; ld_addr=0x21 gives fwd_hit=0.
REQ-045 The bench SHALL cover reset mid-write: RST_N=0 while mem_wr_en=1 and count=2 -> count=0 and mem_wr_en=0 after that edge, with no write reissued after reset.
